// File: rtl/vc_queue_pkg.sv
// Shared sizing helpers for the pipelined valid/ready queue.
package vc_queue_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int DEPTH_DEF = 4;
    localparam int PTR_W_DEF = clog2(DEPTH_DEF);
    localparam int CNT_W_DEF = clog2(DEPTH_DEF + 1);

endpackage

// File: rtl/vc_pipe_queue_if.sv
// Enqueue/dequeue handshake bundle; the queue is the slave, the producer/consumer side the master.
interface vc_pipe_queue_if #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) ();
    import vc_queue_pkg::*;
    localparam int CW = clog2(DEPTH + 1);

    logic          enq_val_p;
    logic          enq_rdy_p;
    logic [W-1:0]  enq_bits_p;
    logic          deq_val_p;
    logic          deq_rdy_p;
    logic [W-1:0]  deq_bits_p;
    logic [CW-1:0] count_p;

    modport slave (
        input  enq_val_p, enq_bits_p, deq_rdy_p,
        output enq_rdy_p, deq_val_p, deq_bits_p, count_p
    );

    modport master (
        output enq_val_p, enq_bits_p, deq_rdy_p,
        input  enq_rdy_p, deq_val_p, deq_bits_p, count_p
    );
endinterface

// File: rtl/vc_queue_ctrl.sv
// Pointer/occupancy control: owns rd/wr pointers and count, derives rdy/val and the storage write enable.
module vc_queue_ctrl
    import vc_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = clog2(DEPTH),
    parameter int CW    = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn_p,
    input  logic          enq_val,
    input  logic          deq_rdy,
    output logic          enq_rdy,
    output logic          deq_val,
    output logic          wr_en,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count
);
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          enq_fire, deq_fire;

    // Readiness comes only from registered count (plus reset), never from deq_rdy.
    assign enq_rdy  = (count_q != CW'(DEPTH)) && resetn_p;
    assign deq_val  = (count_q != '0);
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_fire) wr_ptr_d = wr_ptr_q + PW'(1);
        if (deq_fire) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn_p) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_en  = enq_fire;
    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;
endmodule

// File: rtl/vc_pipe_queue.sv
// Valid/ready FIFO without enq->deq bypass: control sub-block plus an unreset DEPTH x W register file.
module vc_pipe_queue
    import vc_queue_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            resetn_p,
    vc_pipe_queue_if.slave  q
);
    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic          wr_en;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];

    vc_queue_ctrl #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_ctrl (
        .clk      (clk),
        .resetn_p (resetn_p),
        .enq_val  (q.enq_val_p),
        .deq_rdy  (q.deq_rdy_p),
        .enq_rdy  (q.enq_rdy_p),
        .deq_val  (q.deq_val_p),
        .wr_en    (wr_en),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (count)
    );

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_ptr] = q.enq_bits_p;
    end

    // Payload storage is deliberately left out of reset; count/pointers make stale data invisible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign q.deq_bits_p = mem_q[rd_ptr];
    assign q.count_p    = count;
endmodule

// File: tb/tb_vc_pipe_queue.sv
// Directed bench for vc_pipe_queue at W=32, DEPTH=4.
module tb_vc_pipe_queue;
    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic resetn_p;
    int   n_tests;
    int   n_fail;

    vc_pipe_queue_if #(.W(W), .DEPTH(DEPTH)) qif ();

    vc_pipe_queue #(.W(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .resetn_p (resetn_p),
        .q        (qif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn_p = 1'b0;
        qif.enq_val_p  = 1'b1;
        qif.enq_bits_p = 32'hDEAD;
        qif.deq_rdy_p  = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (qif.enq_rdy_p !== 1'b0) begin
                n_fail++; $display("FAIL reset_enq_rdy cyc%0d got %b want 0", i, qif.enq_rdy_p);
            end
            n_tests++;
            if (qif.count_p !== 3'd0) begin
                n_fail++; $display("FAIL reset_count cyc%0d got %0d want 0", i, qif.count_p);
            end
            tick();
        end
        resetn_p = 1'b1;
        qif.enq_val_p = 1'b0;
        qif.deq_rdy_p = 1'b0;
        #1;
        n_tests++;
        if (qif.enq_rdy_p !== 1'b1 || qif.deq_val_p !== 1'b0 || qif.count_p !== 3'd0) begin
            n_fail++;
            $display("FAIL release_idle got rdy=%b val=%b cnt=%0d want 1 0 0",
                     qif.enq_rdy_p, qif.deq_val_p, qif.count_p);
        end
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            qif.enq_val_p  = 1'b1;
            qif.enq_bits_p = 32'hA0 + i;
            #1;
            n_tests++;
            if (qif.enq_rdy_p !== 1'b1 || qif.count_p !== 3'(i)) begin
                n_fail++;
                $display("FAIL fill_step%0d got rdy=%b cnt=%0d want 1 %0d", i, qif.enq_rdy_p, qif.count_p, i);
            end
            tick();
        end
        qif.enq_bits_p = 32'hA4;
        #1;
        n_tests++;
        if (qif.count_p !== 3'd4 || qif.enq_rdy_p !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state got cnt=%0d rdy=%b want 4 0", qif.count_p, qif.enq_rdy_p);
        end
        n_tests++;
        if (qif.deq_val_p !== 1'b1 || qif.deq_bits_p !== 32'hA0) begin
            n_fail++;
            $display("FAIL full_head got val=%b bits=%h want 1 a0", qif.deq_val_p, qif.deq_bits_p);
        end
        tick();
        qif.enq_val_p = 1'b0;
        #1;
        n_tests++;
        if (qif.count_p !== 3'd4) begin
            n_fail++; $display("FAIL fifth_offer got cnt=%0d want 4", qif.count_p);
        end
    endtask

    task automatic test_drain();
        qif.deq_rdy_p = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (qif.deq_val_p !== 1'b1 || qif.deq_bits_p !== 32'hA0 + i || qif.count_p !== 3'(4 - i)) begin
                n_fail++;
                $display("FAIL drain%0d got val=%b bits=%h cnt=%0d want 1 %h %0d",
                         i, qif.deq_val_p, qif.deq_bits_p, qif.count_p, 32'hA0 + i, 4 - i);
            end
            tick();
        end
        #1;
        n_tests++;
        if (qif.deq_val_p !== 1'b0 || qif.count_p !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_empty got val=%b cnt=%0d want 0 0", qif.deq_val_p, qif.count_p);
        end
        // deq_rdy while empty must be harmless
        tick();
        n_tests++;
        if (qif.count_p !== 3'd0 || qif.enq_rdy_p !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_deq got cnt=%0d rdy=%b want 0 1", qif.count_p, qif.enq_rdy_p);
        end
        qif.deq_rdy_p = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            qif.enq_val_p  = 1'b1;
            qif.enq_bits_p = 32'hB0 + i;
            tick();
        end
        qif.deq_rdy_p = 1'b1;
        for (int i = 0; i < 10; i++) begin
            qif.enq_bits_p = 32'hB2 + i;
            #1;
            n_tests++;
            if (qif.count_p !== 3'd2 || qif.deq_bits_p !== 32'hB0 + i || qif.enq_rdy_p !== 1'b1) begin
                n_fail++;
                $display("FAIL simul%0d got cnt=%0d bits=%h rdy=%b want 2 %h 1",
                         i, qif.count_p, qif.deq_bits_p, qif.enq_rdy_p, 32'hB0 + i);
            end
            tick();
        end
        qif.enq_val_p = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if (qif.deq_val_p !== 1'b1 || qif.deq_bits_p !== 32'hBA + i) begin
                n_fail++;
                $display("FAIL simul_tail%0d got val=%b bits=%h want 1 %h",
                         i, qif.deq_val_p, qif.deq_bits_p, 32'hBA + i);
            end
            tick();
        end
        qif.deq_rdy_p = 1'b0;
        #1;
        n_tests++;
        if (qif.count_p !== 3'd0) begin
            n_fail++; $display("FAIL simul_end got cnt=%0d want 0", qif.count_p);
        end
    endtask

    task automatic test_full_both();
        for (int i = 0; i < 4; i++) begin
            qif.enq_val_p  = 1'b1;
            qif.enq_bits_p = 32'hC0 + i;
            tick();
        end
        qif.enq_bits_p = 32'hCF;
        qif.deq_rdy_p  = 1'b1;
        #1;
        n_tests++;
        if (qif.enq_rdy_p !== 1'b0 || qif.deq_bits_p !== 32'hC0) begin
            n_fail++;
            $display("FAIL full_both_pre got rdy=%b bits=%h want 0 c0", qif.enq_rdy_p, qif.deq_bits_p);
        end
        tick();
        qif.enq_val_p = 1'b0;
        qif.deq_rdy_p = 1'b0;
        #1;
        n_tests++;
        if (qif.count_p !== 3'd3 || qif.enq_rdy_p !== 1'b1 || qif.deq_bits_p !== 32'hC1) begin
            n_fail++;
            $display("FAIL full_both_post got cnt=%0d rdy=%b bits=%h want 3 1 c1",
                     qif.count_p, qif.enq_rdy_p, qif.deq_bits_p);
        end
        qif.deq_rdy_p = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            n_tests++;
            if (qif.deq_val_p !== 1'b1 || qif.deq_bits_p !== 32'hC0 + i) begin
                n_fail++;
                $display("FAIL full_both_drain%0d got val=%b bits=%h want 1 %h",
                         i, qif.deq_val_p, qif.deq_bits_p, 32'hC0 + i);
            end
            tick();
        end
        qif.deq_rdy_p = 1'b0;
        #1;
        n_tests++;
        if (qif.deq_val_p !== 1'b0 || qif.count_p !== 3'd0) begin
            n_fail++;
            $display("FAIL full_both_empty got val=%b cnt=%0d want 0 0", qif.deq_val_p, qif.count_p);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            qif.enq_val_p  = 1'b1;
            qif.enq_bits_p = 32'hD0 + i;
            tick();
        end
        qif.enq_bits_p = 32'hDF;
        qif.deq_rdy_p  = 1'b1;
        resetn_p       = 1'b0;
        #1;
        n_tests++;
        if (qif.count_p !== 3'd3 || qif.enq_rdy_p !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_pre got cnt=%0d rdy=%b want 3 0", qif.count_p, qif.enq_rdy_p);
        end
        tick();
        resetn_p      = 1'b1;
        qif.enq_val_p = 1'b0;
        qif.deq_rdy_p = 1'b0;
        #1;
        n_tests++;
        if (qif.count_p !== 3'd0 || qif.deq_val_p !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_post got cnt=%0d val=%b want 0 0", qif.count_p, qif.deq_val_p);
        end
        tick();
        n_tests++;
        if (qif.deq_val_p !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_stale got val=%b want 0", qif.deq_val_p);
        end
        qif.enq_val_p  = 1'b1;
        qif.enq_bits_p = 32'hE0;
        tick();
        qif.enq_val_p = 1'b0;
        #1;
        n_tests++;
        if (qif.count_p !== 3'd1 || qif.deq_val_p !== 1'b1 || qif.deq_bits_p !== 32'hE0) begin
            n_fail++;
            $display("FAIL mid_reset_fresh got cnt=%0d val=%b bits=%h want 1 1 e0",
                     qif.count_p, qif.deq_val_p, qif.deq_bits_p);
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        resetn_p       = 1'b0;
        qif.enq_val_p  = 1'b0;
        qif.enq_bits_p = '0;
        qif.deq_rdy_p  = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_full_both();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vc_pipe_queue.md
VC_PIPE_QUEUE -- requirements
Module: vc_pipe_queue

Interface
REQ-001 The block SHALL have parameter W, default 32: payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4: entry count; power of two, >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn_p, input, 1 bit: synchronous reset, active-low, sampled on the rising clk edge.
REQ-005 The block SHALL have port enq_val_p, input, 1 bit: the producer offers enq_bits_p.
REQ-006 The block SHALL have port enq_rdy_p, output, 1 bit: the queue can accept an entry this cycle.
REQ-007 The block SHALL have port enq_bits_p, input, W bits: the enqueue payload.
REQ-008 The block SHALL have port deq_val_p, output, 1 bit: deq_bits_p holds a valid head entry.
REQ-009 The block SHALL have port deq_rdy_p, input, 1 bit: the consumer takes the head entry.
REQ-010 The block SHALL have port deq_bits_p, output, W bits: the head-entry payload.
REQ-011 The block SHALL have port count_p, output, clog2(DEPTH+1) bits: the current occupancy.

Function
REQ-012 An enqueue fire SHALL be defined as enq_val_p && enq_rdy_p; a dequeue fire SHALL be defined as deq_val_p && deq_rdy_p; each fire SHALL take effect at the next rising clk edge.
REQ-013 The queue SHALL drive enq_rdy_p = (count_p != DEPTH) && resetn_p; a full queue SHALL NOT accept an entry, even when a dequeue fires in the same cycle.
REQ-014 The queue SHALL drive deq_val_p = (count_p != 0); there SHALL be no enq-to-deq bypass, so minimum latency from enqueue fire to deq_val_p is 1 cycle.
REQ-015 The queue SHALL drive deq_bits_p as storage[rd_ptr], combinationally from registered state; deq_bits_p is don't-care while deq_val_p = 0.
REQ-016 On an enqueue fire the queue SHALL write storage[wr_ptr] and advance wr_ptr modulo DEPTH; on a dequeue fire it SHALL advance rd_ptr modulo DEPTH.
REQ-017 The queue SHALL update count as follows: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither; count SHALL never leave the range 0..DEPTH.
REQ-018 Pointer width SHALL be clog2(DEPTH); wrap-around SHALL be the natural pointer-width overflow, with no extra logic.
REQ-019 The queue SHALL preserve FIFO order exactly; no entry SHALL be lost or duplicated across any combination of simultaneous fires.
REQ-020 Input activity SHALL leave state unchanged: enq_val_p while full, and deq_rdy_p while empty, SHALL have no effect.
REQ-021 The queue SHALL NOT place any combinational path from deq_rdy_p to enq_rdy_p, nor from enq_val_p to deq_val_p.

Reset
REQ-022 While resetn_p = 0 at a rising edge, the queue SHALL clear rd_ptr, wr_ptr and count to 0; storage contents SHALL NOT be reset.
REQ-023 After reset, the outputs SHALL be count_p = 0 and deq_val_p = 0; enq_rdy_p SHALL be held 0 while resetn_p = 0 and SHALL return to 1 in the first cycle with resetn_p = 1.
REQ-024 Reset asserted mid-operation SHALL take priority over any simultaneous fire and SHALL discard all held entries.

Structure
REQ-025 A shared package vc_queue_pkg SHALL hold the clog2 function and the derived pointer-width and count-width constants.
REQ-026 One sub-module, vc_queue_ctrl, SHALL hold the pointers, count, rdy/val logic and write-enable output; vc_pipe_queue SHALL instantiate it together with the DEPTH x W storage array.
REQ-027 The storage array SHALL be enabled flip-flops without reset, written only on an enqueue fire.

Verification
REQ-028 The bench SHALL cover reset then idle: resetn_p held 0 for 2 cycles -> enq_rdy_p = 0 and count_p = 0 during reset; enq_rdy_p = 1 and deq_val_p = 0 on the first cycle after release.
REQ-029 The bench SHALL cover fill to full, DEPTH = 4: enqueue 0xA0..0xA3 on back-to-back cycles with deq_rdy_p = 0 -> count_p = 4, enq_rdy_p = 0; a fifth offer of 0xA4 is not accepted.
REQ-030 The bench SHALL cover drain: deq_rdy_p = 1 from full -> deq_bits_p = 0xA0, 0xA1, 0xA2, 0xA3 on successive cycles, then deq_val_p = 0 and count_p = 0.
REQ-031 The bench SHALL cover simultaneous fires at count 2: enqueue and dequeue both fire for 10 cycles -> count_p stays 2, pointers wrap at least twice, output order matches input order.
REQ-032 The bench SHALL cover full with both sides active: count 4, enq_val_p = 1 and deq_rdy_p = 1 -> head dequeued, new entry not accepted, count_p = 3 next cycle, enq_rdy_p = 1.
REQ-033 The bench SHALL cover mid-operation reset: resetn_p = 0 at count 3 while both sides fire -> count_p = 0 and deq_val_p = 0 next cycle; no stale entry appears after release.
